// File: rtl/ila_monitor_pkg.sv
// Shared types for the ILA run monitor: FSM state encoding, verdict codes and
// the registered verdict bundle.
package common;

    localparam logic RESET = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } ila_state_t;

    localparam logic [1:0] FAIL_NONE        = 2'b00;
    localparam logic [1:0] FAIL_MISMATCH    = 2'b01;
    localparam logic [1:0] FAIL_TIMEOUT     = 2'b10;
    localparam logic [1:0] FAIL_OVER_RETIRE = 2'b11;

    typedef struct packed {
        logic       done;
        logic       pass;
        logic [1:0] fail_code;
    } ila_verdict_t;

endpackage

// File: rtl/ila_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats enable.
module ila_sat_counter
    import common::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst == RESET || clr) begin
            cnt <= '0;
        end else if (en && cnt != {W{1'b1}}) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/ila_monitor.sv
// Run monitor for an ILA test program: counts cycles and retires, waits for both
// checkers to agree, and latches a verdict. Define ILA_FIRST_ERR_EN for first-error capture.
module ila_monitor
    import common::*;
#(
    parameter int EXP_RETIRE     = 9,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             retire,
    input  logic             rm_ok,
    input  logic             dm_ok,
    output logic             done,
    output logic             pass,
    output logic [1:0]       fail_code,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output ila_state_t       state,
    output logic [CNT_W-1:0] err_cycle,
    output logic [1:0]       err_src
);

    localparam logic [CNT_W-1:0] LAST_RET = CNT_W'(EXP_RETIRE - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);

    ila_state_t       nxt_state;
    logic [1:0]       nxt_fail;
    ila_verdict_t     vd_q, vd_nxt;
    logic [CNT_W-1:0] settle_cnt;
    logic             ok, arm;
    logic             cyc_en, ret_en, set_en, set_clr;

    assign ok  = rm_ok && dm_ok;
    assign arm = (state == IDLE || state == DONE) && start;

    // State register
    always_ff @(posedge clk) begin
        if (rst == RESET) state <= IDLE;
        else              state <= nxt_state;
    end

    // Next state and the verdict that goes with entering DONE
    always_comb begin
        nxt_state = state;
        nxt_fail  = FAIL_NONE;
        case (state)
            IDLE, DONE: begin
                if (start) nxt_state = RUN;
            end
            RUN: begin
                // Final retire wins over a coinciding timeout
                if (retire && retire_cnt == LAST_RET) begin
                    nxt_state = SETTLE;
                end else if (cycle_cnt == TO_LAST) begin
                    nxt_state = DONE;
                    nxt_fail  = FAIL_TIMEOUT;
                end
            end
            SETTLE: begin
                // >= so a settle entered on the last run cycle still times out
                if (retire) begin
                    nxt_state = DONE;
                    nxt_fail  = FAIL_OVER_RETIRE;
                end else if (ok && settle_cnt == SET_LAST) begin
                    nxt_state = DONE;
                    nxt_fail  = FAIL_NONE;
                end else if (cycle_cnt >= TO_LAST) begin
                    nxt_state = DONE;
                    nxt_fail  = FAIL_MISMATCH;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Output/next-value logic: verdict and counter controls
    always_comb begin
        vd_nxt = vd_q;
        if (arm) begin
            vd_nxt = '0;
        end else if (state != DONE && nxt_state == DONE) begin
            vd_nxt.done      = 1'b1;
            vd_nxt.pass      = (nxt_fail == FAIL_NONE);
            vd_nxt.fail_code = nxt_fail;
        end
        cyc_en  = (state == RUN) || (state == SETTLE);
        ret_en  = (state == RUN) && retire;
        set_en  = (state == SETTLE) && ok;
        set_clr = arm || ((state == SETTLE) && !ok);
    end

    always_ff @(posedge clk) begin
        if (rst == RESET) vd_q <= '0;
        else              vd_q <= vd_nxt;
    end

    assign done      = vd_q.done;
    assign pass      = vd_q.pass;
    assign fail_code = vd_q.fail_code;

    ila_sat_counter #(.W(CNT_W)) u_cyc_cnt (
        .clk (clk),
        .rst (rst),
        .clr (arm),
        .en  (cyc_en),
        .cnt (cycle_cnt)
    );

    ila_sat_counter #(.W(CNT_W)) u_ret_cnt (
        .clk (clk),
        .rst (rst),
        .clr (arm),
        .en  (ret_en),
        .cnt (retire_cnt)
    );

    ila_sat_counter #(.W(CNT_W)) u_set_cnt (
        .clk (clk),
        .rst (rst),
        .clr (set_clr),
        .en  (set_en),
        .cnt (settle_cnt)
    );

`ifdef ILA_FIRST_ERR_EN
    logic [CNT_W-1:0] err_cycle_q;
    logic [1:0]       err_src_q;

    // A captured error always has a nonzero source, so err_src_q doubles as the lock
    always_ff @(posedge clk) begin
        if (rst == RESET || arm) begin
            err_cycle_q <= '0;
            err_src_q   <= '0;
        end else if (state == SETTLE && !ok && err_src_q == 2'b00) begin
            err_cycle_q <= cycle_cnt;
            err_src_q   <= {~dm_ok, ~rm_ok};
        end
    end

    assign err_cycle = err_cycle_q;
    assign err_src   = err_src_q;
`else
    assign err_cycle = '0;
    assign err_src   = '0;
`endif

endmodule

// File: tb/tb_ila_monitor.sv
// Randomized scoreboard bench for ila_monitor: a rule-level model predicts each
// run's verdict, and a done-edge monitor pops and compares.
module tb_ila_monitor;
    import common::*;

    localparam int EXP = 9;
    localparam int SET = 4;
    localparam int TO  = 64;
    localparam int W   = 16;
    localparam int N   = TO + 16;

    logic clk = 1'b0;
    logic rst, start, retire, rm_ok, dm_ok;
    logic done, pass;
    logic [1:0] fail_code, err_src;
    logic [W-1:0] cycle_cnt, retire_cnt, err_cycle;
    ila_state_t state;

    ila_monitor #(
        .EXP_RETIRE(EXP), .SETTLE_CYCLES(SET), .TIMEOUT_CYCLES(TO), .CNT_W(W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .retire(retire),
        .rm_ok(rm_ok), .dm_ok(dm_ok), .done(done), .pass(pass),
        .fail_code(fail_code), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt),
        .state(state), .err_cycle(err_cycle), .err_src(err_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        int fc;
        int pass;
        int rcnt;
        int ccnt;
        int ecyc;
        int esrc;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    bit   ret_a[N];
    bit   rm_a[N];
    bit   dm_a[N];

    function automatic void chk(string nm, int act, int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endfunction

    // Verdict from the rules: find the EXP-th retire inside the timeout window,
    // then scan settle cycles for over-retire, a SET-long ok streak, or timeout.
    // Cycle index k equals cycle_cnt during that cycle.
    task automatic model(output exp_t e, output int kdec);
        int nret = 0;
        int r9 = -1;
        int streak = 0;
        e = '{fc: 0, pass: 0, rcnt: 0, ccnt: 0, ecyc: 0, esrc: 0};
        kdec = TO - 1;
        for (int k = 0; k < TO; k++) begin
            if (ret_a[k]) begin
                nret++;
                if (nret == EXP) begin
                    r9 = k;
                    break;
                end
            end
        end
        if (r9 < 0) begin
            e.fc   = 2;
            e.rcnt = nret;
        end else begin
            e.rcnt = EXP;
            for (int k = r9 + 1; k < N; k++) begin
                bit okk = rm_a[k] && dm_a[k];
                if (!okk && e.esrc == 0) begin
                    e.ecyc = k;
                    e.esrc = (dm_a[k] ? 0 : 2) + (rm_a[k] ? 0 : 1);
                end
                kdec   = k;
                streak = okk ? streak + 1 : 0;
                if (ret_a[k]) begin
                    e.fc = 3;
                    break;
                end
                if (streak == SET) begin
                    e.fc = 0;
                    break;
                end
                if (k >= TO - 1) begin
                    e.fc = 1;
                    break;
                end
            end
        end
`ifndef ILA_FIRST_ERR_EN
        e.ecyc = 0;
        e.esrc = 0;
`endif
        e.pass = (e.fc == 0) ? 1 : 0;
        e.ccnt = kdec + 1;
    endtask

    // Monitor: compare on every rising edge of done
    logic done_q = 1'b0;
    always @(negedge clk) begin
        if (done && !done_q) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("state_done", int'(state), int'(DONE));
                chk("fail_code", int'(fail_code), e.fc);
                chk("pass", int'(pass), e.pass);
                chk("retire_cnt", int'(retire_cnt), e.rcnt);
                chk("cycle_cnt", int'(cycle_cnt), e.ccnt);
                chk("err_cycle", int'(err_cycle), e.ecyc);
                chk("err_src", int'(err_src), e.esrc);
            end
        end
        done_q = done;
    end

    task automatic clear_arrays();
        for (int i = 0; i < N; i++) begin
            ret_a[i] = 1'b0;
            rm_a[i]  = 1'b1;
            dm_a[i]  = 1'b1;
        end
    endtask

    task automatic place_retires(input int n, input int span);
        int c = 0;
        while (c < n) begin
            int p = int'($urandom_range(span - 1));
            if (!ret_a[p]) begin
                ret_a[p] = 1'b1;
                c++;
            end
        end
    endtask

    function automatic int last_ret();
        int l = -1;
        for (int i = 0; i < N; i++) if (ret_a[i]) l = i;
        return l;
    endfunction

    task automatic run_case();
        exp_t e;
        int kdec;
        int w = 0;
        model(e, kdec);
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k <= kdec; k++) begin
            retire = ret_a[k];
            rm_ok  = rm_a[k];
            dm_ok  = dm_a[k];
            @(negedge clk);
        end
        retire = 1'b0;
        while (sbq.size() != 0 && w < 8) begin
            @(negedge clk);
            w++;
        end
        if (sbq.size() != 0) begin
            chk("done_timeout", 0, 1);
            void'(sbq.pop_front());
        end
        // Verdict and counters must hold while parked in DONE
        @(negedge clk);
        chk("hold_done", int'(done), 1);
        chk("hold_cycle_cnt", int'(cycle_cnt), e.ccnt);
        chk("hold_fail_code", int'(fail_code), e.fc);
    endtask

    task automatic check_idle_zero(string tag);
        chk({tag, "_state"}, int'(state), int'(IDLE));
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_pass"}, int'(pass), 0);
        chk({tag, "_fail_code"}, int'(fail_code), 0);
        chk({tag, "_cycle_cnt"}, int'(cycle_cnt), 0);
        chk({tag, "_retire_cnt"}, int'(retire_cnt), 0);
        chk({tag, "_err_cycle"}, int'(err_cycle), 0);
        chk({tag, "_err_src"}, int'(err_src), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int r9;
        rst = 1'b0; start = 1'b0; retire = 1'b0; rm_ok = 1'b1; dm_ok = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // Clean pass: 9 retires within 20 cycles, oks high
        clear_arrays(); place_retires(EXP, 20); run_case();

        // Timeout with only 5 retires
        clear_arrays(); place_retires(5, 20); run_case();

        // dm checker disagrees throughout settle
        clear_arrays(); place_retires(EXP, 20);
        for (int i = 0; i < N; i++) dm_a[i] = 1'b0;
        run_case();

        // Extra retire during settle
        clear_arrays(); place_retires(EXP, 20);
        r9 = last_ret();
        ret_a[r9 + 1 + int'($urandom_range(2))] = 1'b1;
        run_case();

        // Streak broken once: 3 ok, 1 bad, 4 ok
        clear_arrays(); place_retires(EXP, 20);
        r9 = last_ret();
        rm_a[r9 + 4] = 1'b0;
        dm_a[r9 + 4] = 1'b0;
        run_case();

        // Randomized runs
        for (int t = 0; t < 20; t++) begin
            int rp = int'($urandom_range(5, 30));
            int op = int'($urandom_range(0, 20));
            clear_arrays();
            for (int i = 0; i < N; i++) begin
                ret_a[i] = ($urandom_range(99) < rp);
                rm_a[i]  = ($urandom_range(99) >= op);
                dm_a[i]  = ($urandom_range(99) >= op);
            end
            run_case();
        end

        // Reset mid-run with start and retire asserted
        clear_arrays();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        retire = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrun_state", int'(state), int'(RUN));
        rst = 1'b0; start = 1'b1; retire = 1'b1;
        @(negedge clk);
        check_idle_zero("midrun_rst");
        rst = 1'b1; start = 1'b0; retire = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_state", int'(state), int'(IDLE));
        chk("post_rst_cycle_cnt", int'(cycle_cnt), 0);

        // A normal run still works after the reset
        clear_arrays(); place_retires(EXP, 20); run_case();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
